// File: rtl/imm_pkg.sv
// Shared immediate-format definitions: format enum, per-format field masks and
// the field packing helper used by the encoder datapath.
package imm_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned INSN_W = 32;
   localparam int unsigned FMT_W  = 3;

   typedef enum logic [FMT_W-1:0] {
      FMT_I     = 3'd0,
      FMT_S     = 3'd1,
      FMT_B     = 3'd2,
      FMT_U     = 3'd3,
      FMT_J     = 3'd4,
      FMT_SHAMT = 3'd5,
      FMT_ZIMM  = 3'd6
   } imm_fmt_t;

   localparam logic [INSN_W-1:0] MASK_I     = 32'hFFF0_0000;
   localparam logic [INSN_W-1:0] MASK_S     = 32'hFE00_0F80;
   localparam logic [INSN_W-1:0] MASK_B     = 32'hFE00_0F80;
   localparam logic [INSN_W-1:0] MASK_U     = 32'hFFFF_F000;
   localparam logic [INSN_W-1:0] MASK_J     = 32'hFFFF_F000;
   localparam logic [INSN_W-1:0] MASK_SHAMT = 32'h03F0_0000;
   localparam logic [INSN_W-1:0] MASK_ZIMM  = 32'h000F_8000;

   function automatic logic fmt_legal(input logic [FMT_W-1:0] fmt);
      return fmt <= FMT_W'(FMT_ZIMM);
   endfunction

   // Instruction bits owned by the immediate; illegal formats own nothing.
   function automatic logic [INSN_W-1:0] fmt_mask(input logic [FMT_W-1:0] fmt);
      logic [INSN_W-1:0] m;
      m = '0;
      case (imm_fmt_t'(fmt))
         FMT_I:     m = MASK_I;
         FMT_S:     m = MASK_S;
         FMT_B:     m = MASK_B;
         FMT_U:     m = MASK_U;
         FMT_J:     m = MASK_J;
         FMT_SHAMT: m = MASK_SHAMT;
         FMT_ZIMM:  m = MASK_ZIMM;
         default:   m = '0;
      endcase
      return m;
   endfunction

   // Scatter the low immediate bits into their instruction positions.
   function automatic logic [INSN_W-1:0] imm_pack(input logic [FMT_W-1:0] fmt,
                                                   input logic [INSN_W-1:0] imm);
      logic [INSN_W-1:0] b;
      b = '0;
      case (imm_fmt_t'(fmt))
         FMT_I: b[31:20] = imm[11:0];
         FMT_S: begin
            b[31:25] = imm[11:5];
            b[11:7]  = imm[4:0];
         end
         FMT_B: begin
            b[31]    = imm[12];
            b[30:25] = imm[10:5];
            b[11:8]  = imm[4:1];
            b[7]     = imm[11];
         end
         FMT_U: b[31:12] = imm[31:12];
         FMT_J: begin
            b[31]    = imm[20];
            b[30:21] = imm[10:1];
            b[20]    = imm[11];
            b[19:12] = imm[19:12];
         end
         FMT_SHAMT: b[25:20] = imm[5:0];
         FMT_ZIMM:  b[19:15] = imm[4:0];
         default:   b = '0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational representability check of a 64-bit immediate for a given format.
module imm_range_chk
   import imm_pkg::*;
(
   input  logic [FMT_W-1:0] fmt,
   input  logic [XLEN-1:0]  imm,
   output logic             err
);

   logic sext12, sext13, sext21, sext32;

   // Value equals the sign extension of its low N bits.
   assign sext12 = (imm == {{52{imm[11]}}, imm[11:0]});
   assign sext13 = (imm == {{51{imm[12]}}, imm[12:0]});
   assign sext21 = (imm == {{43{imm[20]}}, imm[20:0]});
   assign sext32 = (imm == {{32{imm[31]}}, imm[31:0]});

   always_comb begin
      err = 1'b0;
      case (imm_fmt_t'(fmt))
         FMT_I, FMT_S: err = !sext12;
         FMT_B:        err = !sext13 || imm[0];
         FMT_J:        err = !sext21 || imm[0];
         FMT_U:        err = !sext32 || (imm[11:0] != 12'd0);
         FMT_SHAMT:    err = (imm[63:6] != 58'd0);
         FMT_ZIMM:     err = (imm[63:5] != 59'd0);
         default:      err = 1'b0;
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder that packs an immediate into a base RV64 instruction.
// Build option IMM_ENC_RANGE_CHECK_EN enables range errors; otherwise only illegal formats flag.
module imm_encoder
   import imm_pkg::*;
#(
   parameter int unsigned TAG_W = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FMT_W-1:0]  in_fmt,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [INSN_W-1:0] in_base,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INSN_W-1:0] out_instr,
   output logic              out_err,
   output logic [TAG_W-1:0]  out_tag
);

   logic              s1_valid, s2_valid;
   logic              s1_adv, s2_adv;
   logic [INSN_W-1:0] s1_base, s1_mask, s1_bits;
   logic              s1_err;
   logic [TAG_W-1:0]  s1_tag;
   logic              range_err;

   // Ready propagates combinationally back through both stages.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

`ifdef IMM_ENC_RANGE_CHECK_EN
   imm_range_chk u_range_chk (
      .fmt (in_fmt),
      .imm (in_imm),
      .err (range_err)
   );
`else
   logic unused_imm_hi;
   assign range_err     = 1'b0;
   assign unused_imm_hi = ^in_imm[XLEN-1:INSN_W];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_base   <= '0;
         s1_mask   <= '0;
         s1_bits   <= '0;
         s1_err    <= 1'b0;
         s1_tag    <= '0;
         s2_valid  <= 1'b0;
         out_instr <= '0;
         out_err   <= 1'b0;
         out_tag   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_base <= in_base;
               s1_mask <= fmt_mask(in_fmt);
               s1_bits <= imm_pack(in_fmt, in_imm[INSN_W-1:0]);
               s1_err  <= !fmt_legal(in_fmt) || range_err;
               s1_tag  <= in_tag;
            end
         end
         // Merge stage: keep opcode/funct/register bits, replace immediate fields.
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_instr <= (s1_base & ~s1_mask) | s1_bits;
               out_err   <= s1_err;
               out_tag   <= s1_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed steps with a scoreboard queue.
module tb_imm_encoder;
   import imm_pkg::*;

   localparam int unsigned TAG_W = 4;
`ifdef IMM_ENC_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      logic [31:0]      instr;
      logic             err;
      logic [TAG_W-1:0] tag;
      bit               lat;
      int               pcyc;
   } exp_t;

   logic             clk, reset, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [2:0]       in_fmt;
   logic [63:0]      in_imm;
   logic [31:0]      in_base, out_instr;
   logic [TAG_W-1:0] in_tag, out_tag;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t q[$];

   imm_encoder #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_imm    (in_imm),
      .in_base   (in_base),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, got, exp);
      end
   endtask

   // Independent reference: overwrite fields directly, range via signed bounds.
   function automatic exp_t model(input logic [2:0] fmt, input logic [63:0] imm,
                                  input logic [31:0] base);
      exp_t   e;
      longint s;
      logic   bad;
      s = $signed(imm);
      e.instr = base;
      e.tag = '0;
      e.lat = 1'b0;
      e.pcyc = 0;
      bad = 1'b0;
      case (fmt)
         3'd0: begin
            e.instr[31:20] = imm[11:0];
            bad = !(s >= -64'sd2048 && s <= 64'sd2047);
         end
         3'd1: begin
            e.instr[31:25] = imm[11:5];
            e.instr[11:7]  = imm[4:0];
            bad = !(s >= -64'sd2048 && s <= 64'sd2047);
         end
         3'd2: begin
            e.instr[31]    = imm[12];
            e.instr[30:25] = imm[10:5];
            e.instr[11:8]  = imm[4:1];
            e.instr[7]     = imm[11];
            bad = !(s >= -64'sd4096 && s <= 64'sd4095) || imm[0];
         end
         3'd3: begin
            e.instr[31:12] = imm[31:12];
            bad = !(s >= -64'sd2147483648 && s <= 64'sd2147483647) || (imm[11:0] != 12'd0);
         end
         3'd4: begin
            e.instr[31]    = imm[20];
            e.instr[30:21] = imm[10:1];
            e.instr[20]    = imm[11];
            e.instr[19:12] = imm[19:12];
            bad = !(s >= -64'sd1048576 && s <= 64'sd1048575) || imm[0];
         end
         3'd5: begin
            e.instr[25:20] = imm[5:0];
            bad = !(imm < 64'd64);
         end
         3'd6: begin
            e.instr[19:15] = imm[4:0];
            bad = !(imm < 64'd32);
         end
         default: bad = 1'b0;
      endcase
      e.err = (fmt == 3'd7) ? 1'b1 : (RC & bad);
      return e;
   endfunction

   // Drive one request from posedge+1; push its expectation on the accepting edge.
   task automatic send(input logic [2:0] fmt, input logic [63:0] imm, input logic [31:0] base,
                       input logic [TAG_W-1:0] tag, input bit ovr, input logic [31:0] xi,
                       input logic xe, input bit lat);
      exp_t e;
      bit   ok;
      e = model(fmt, imm, base);
      if (ovr) begin
         e.instr = xi;
         e.err   = xe;
      end
      e.tag = tag;
      e.lat = lat;
      in_valid = 1'b1;
      in_fmt   = fmt;
      in_imm   = imm;
      in_base  = base;
      in_tag   = tag;
      ok = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) begin
            e.pcyc = cyc;
            q.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   // Output monitor: scoreboard pops, latency and stall stability.
   initial begin
      exp_t             e;
      bit               hold;
      logic [31:0]      h_instr;
      logic             h_err;
      logic [TAG_W-1:0] h_tag;
      hold = 1'b0;
      h_instr = '0;
      h_err = 1'b0;
      h_tag = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            q.delete();
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_instr", 64'(out_instr), 64'(h_instr));
               chk("stall_err",   64'(out_err),   64'(h_err));
               chk("stall_tag",   64'(out_tag),   64'(h_tag));
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("spurious_out", 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk("instr", 64'(out_instr), 64'(e.instr));
                  chk("err",   64'(out_err),   64'(e.err));
                  chk("tag",   64'(out_tag),   64'(e.tag));
                  if (e.lat) chk("latency", 64'(cyc - e.pcyc), 64'd2);
               end
            end
            hold    = out_valid && !out_ready;
            h_instr = out_instr;
            h_err   = out_err;
            h_tag   = out_tag;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint v;
      logic [2:0]  f;
      logic [63:0] imm;
      reset = 1'b1;
      in_valid = 1'b0;
      in_fmt = '0;
      in_imm = '0;
      in_base = '0;
      in_tag = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_err",   64'(out_err),   64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Directed cases with hand-derived results.
      send(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 4'd1, 1, 32'hFFF0_0013, 1'b0, 1);
      wait_drain();
      send(3'd2, 64'h800, 32'h0000_0063, 4'd2, 1, 32'h0000_00E3, 1'b0, 0);
      send(3'd2, 64'h801, 32'h0000_0063, 4'd3, 1, 32'h0000_00E3, RC, 0);
      send(3'd3, 64'h1234_5000, 32'h0000_0037, 4'd4, 1, 32'h1234_5037, 1'b0, 0);
      send(3'd3, 64'h8000_0000, 32'h0000_0037, 4'd5, 1, 32'h8000_0037, RC, 0);
      send(3'd5, 64'd63, 32'h4000_5013, 4'd6, 1, 32'h43F0_5013, 1'b0, 0);
      send(3'd6, 64'd31, 32'h0000_5073, 4'd7, 1, 32'h000F_D073, 1'b0, 0);
      send(3'd7, 64'd5, 32'h1234_5678, 4'd8, 1, 32'h1234_5678, 1'b1, 0);
      wait_drain();

      // Representability boundaries, checked through the model.
      send(3'd0, -64'sd2048, 32'h0000_0013, 4'd0, 0, '0, 1'b0, 0);
      send(3'd0, 64'sd2047, 32'h0000_0013, 4'd1, 0, '0, 1'b0, 0);
      send(3'd0, 64'sd2048, 32'h0000_0013, 4'd2, 0, '0, 1'b0, 0);
      send(3'd2, -64'sd4096, 32'h0000_0063, 4'd3, 0, '0, 1'b0, 0);
      send(3'd2, 64'sd4094, 32'h0000_0063, 4'd4, 0, '0, 1'b0, 0);
      send(3'd2, 64'sd4096, 32'h0000_0063, 4'd5, 0, '0, 1'b0, 0);
      send(3'd4, -64'sd1048576, 32'h0000_006F, 4'd6, 0, '0, 1'b0, 0);
      send(3'd4, 64'sd1048574, 32'h0000_006F, 4'd7, 0, '0, 1'b0, 0);
      send(3'd4, 64'sd1048575, 32'h0000_006F, 4'd8, 0, '0, 1'b0, 0);
      send(3'd1, -64'sd1, 32'h0000_3023, 4'd9, 0, '0, 1'b0, 0);
      send(3'd5, 64'd64, 32'h0000_1013, 4'd10, 0, '0, 1'b0, 0);
      send(3'd6, 64'd32, 32'h0000_5073, 4'd11, 0, '0, 1'b0, 0);
      wait_drain();

      // Mixed random requests.
      for (int i = 0; i < 16; i++) begin
         f = 3'($urandom_range(0, 7));
         if (i % 2 == 0) begin
            v = longint'($signed(32'($urandom))) >>> $urandom_range(0, 28);
            imm = 64'(v);
         end else begin
            imm = {32'($urandom), 32'($urandom)};
         end
         send(f, imm, 32'($urandom), 4'(i), 0, '0, 1'b0, 0);
      end
      wait_drain();

      // Back-to-back stream with a three-cycle output stall.
      fork
         begin
            for (int t = 0; t < 8; t++) begin
               v = longint'(t * 100 - 300);
               send(3'd0, 64'(v), 32'h0000_0013 | 32'(t << 7), 4'(t), 0, '0, 1'b0, 0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("in_ready_full", 64'(in_ready), 64'd0);
            @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset with two requests in flight.
      out_ready = 1'b0;
      send(3'd0, 64'd5, 32'h0000_0013, 4'd12, 0, '0, 1'b0, 0);
      send(3'd0, 64'd6, 32'h0000_0013, 4'd13, 0, '0, 1'b0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale", 64'(out_valid), 64'd0);
      end
      send(3'd0, 64'd7, 32'h0000_0013, 4'd14, 1, 32'h0070_0013, 1'b0, 0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
